// File: rtl/lsu_sram_ctrl_pkg.sv
// Shared types and constants for the LSU data-memory slave.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lsu_sram_ctrl_pkg;

    // Request lifecycle: accept in IDLE, count down in WAIT, hold the response in RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bit positions 7,5,4,3).
    localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
    localparam logic [31:0] BASE_DEFAULT = 32'h8000_0000;
    localparam int          WORD_W       = 32;
    localparam int          STRB_W       = 4;
    localparam int          CNT_W        = 16;

endpackage

// File: rtl/lsu_lat_lfsr.sv
// 8-bit maximal-length LFSR used to draw pseudo-random access latencies.
// Latency: new value every cycle; output is the registered state.
// Backpressure: none, free-running regardless of the controller state.
module lsu_lat_lfsr
    import lsu_sram_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [7:0] o_value
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb    = ^(r_lfsr & LFSR_TAPS);
    assign o_value = r_lfsr;

    // Shift every cycle; a nonzero seed keeps the sequence out of the all-zero lockup state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Word-array data memory behind a single-outstanding valid/ready request/response port.
// Latency: accept-to-rsp_valid is FIX_LAT+1 cycles, or 2..5 cycles from the LFSR when FIX_LAT=0.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
module lsu_sram_ctrl
    import lsu_sram_ctrl_pkg::*;
#(
    parameter int          AW        = 10,
    parameter logic [31:0] BASE      = BASE_DEFAULT,
    parameter int          FIX_LAT   = 0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int               LAT_M1    = (FIX_LAT > 0) ? FIX_LAT - 1 : 0;
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LAT_M1);
    localparam logic [32:0]      MEM_BYTES = 33'(4) << AW;

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wmask;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-1:0]   r_rdata;
    logic                r_err;
    logic [WORD_W-1:0]   r_mem [0:(1<<AW)-1];

    logic [7:0]          w_lfsr;
    logic                w_unused;
    logic [31:0]         w_off;
    logic [AW-1:0]       w_idx;
    logic                w_in_range;
    logic                w_accept;
    logic                w_access;
    logic                w_mem_we;

    lsu_lat_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst   (rst),
        .o_value (w_lfsr)
    );

    // Only the two low LFSR bits pick the latency; the rest is just sequence state.
    assign w_unused = ^w_lfsr[7:2];

    // Offset wraps to a huge value for addresses below BASE, so one compare covers both bounds.
    assign w_off      = r_addr - BASE;
    assign w_idx      = w_off[AW+1:2];
    assign w_in_range = ({1'b0, w_off} < MEM_BYTES);

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    // Reset wins over an access that would otherwise happen this cycle, so a pending store is dropped.
    assign w_access = (r_state == ST_WAIT) && (r_cnt == '0) && !rst;
    assign w_mem_we = w_access && r_we && w_in_range;

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
                r_cnt   <= (FIX_LAT > 0) ? LAT_LOAD : {{(CNT_W-2){1'b0}}, w_lfsr[1:0]};
            end
            if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                if (!w_in_range) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (r_we) begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end else begin
                    r_rdata <= r_mem[w_idx];
                    r_err   <= 1'b0;
                end
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    // Byte-lane masked store into the backing array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (r_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Self-checking bench: one fixed-latency and one random-latency instance against a word-map model.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low and by asserting it early.
module tb_lsu_sram_ctrl;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] LIMIT = 32'h8000_1000;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  rsp_ready;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata [2];

    int checks = 0;
    int errors = 0;
    bit lfsr_zero_seen = 1'b0;
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    lsu_sram_ctrl #(.AW(10), .BASE(BASE), .FIX_LAT(0), .LFSR_SEED(8'hA5)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    lsu_sram_ctrl #(.AW(10), .BASE(BASE), .FIX_LAT(1), .LFSR_SEED(8'hA5)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // The latency LFSR must never sit at zero once seeded.
    always @(negedge clk) begin
        if (dut0.u_lfsr.o_value == 8'h00) lfsr_zero_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: a map of word index -> value, byte strobes merged arithmetically.
    function automatic void model(input int s, input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wmask,
                                  output logic [31:0] erd, output logic eerr);
        int key;
        logic [31:0] w;
        if (addr < BASE || addr >= LIMIT) begin
            erd  = 32'h0;
            eerr = 1'b1;
            return;
        end
        key  = s * 2048 + int'((addr - BASE) >> 2);
        eerr = 1'b0;
        if (we) begin
            w = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
            mdl[key] = w;
            erd = 32'h0;
        end else begin
            erd = mdl.exists(key) ? mdl[key] : 32'hx;
        end
    endfunction

    // One full transaction; early=1 raises rsp_ready before the response exists.
    task automatic do_req(input int s, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input bit early, input int stall,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready[s]}, 32'd1);
        req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr;
        req_wdata[s] = wdata; req_wmask[s] = wmask;
        rsp_ready[s] = early;
        @(negedge clk);
        req_valid[s] = 1'b0;
        lat = 1;
        while (!rsp_valid[s] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_seen", {31'b0, rsp_valid[s]}, 32'd1);
        rd = rsp_rdata[s];
        er = rsp_err[s];
        if (!early) begin
            repeat (stall) @(negedge clk);
            rsp_ready[s] = 1'b1;
        end
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        chk("rsp_valid_drop", {31'b0, rsp_valid[s]}, 32'd0);
        chk("req_ready_back", {31'b0, req_ready[s]}, 32'd1);
    endtask

    task automatic txn(input string tag, input int s, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input bit early, input int stall);
        logic [31:0] erd, rd;
        logic eerr, er;
        int lat;
        model(s, we, addr, wdata, wmask, erd, eerr);
        do_req(s, we, addr, wdata, wmask, early, stall, rd, er, lat);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, {31'b0, er}, {31'b0, eerr});
        if (s == 1) chk({tag, "_lat_fixed"}, lat, 32'd2);
        else        chk({tag, "_lat_range"}, {31'b0, (lat >= 2 && lat <= 5)}, 32'd1);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  m;
        bit          we;
        int          n;
        logic [31:0] oor [4];

        rst = 2'b11; req_valid = '0; req_we = '0; rsp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = '0; req_wdata[i] = '0; req_wmask[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", {31'b0, req_ready[i]}, 32'd1);
            chk("rst_rsp_valid", {31'b0, rsp_valid[i]}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
            chk("rst_rsp_err",   {31'b0, rsp_err[i]}, 32'd0);
        end
        chk("rst_lfsr_seed", {24'b0, dut0.u_lfsr.o_value}, 32'h0000_00A5);
        rst = 2'b00;

        // Fixed latency: store then load the same word.
        txn("st_deadbeef", 1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
        txn("ld_deadbeef", 1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 0);

        // Partial store on one byte lane.
        txn("st_base_word", 1, 1'b1, 32'h8000_0040, 32'h1122_3344, 4'hF, 1'b0, 0);
        txn("st_lane1",     1, 1'b1, 32'h8000_0040, 32'h0000_AB00, 4'b0010, 1'b0, 0);
        txn("ld_lane1",     1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 1'b0, 0);
        txn("st_mask0",     1, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'h0, 1'b0, 0);
        txn("ld_mask0",     1, 1'b0, 32'h8000_0042, 32'h0, 4'h0, 1'b0, 0);

        // Backpressure: hold the response while a hostile store is offered.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h8000_0010;
        @(negedge clk);
        req_valid[1] = 1'b0;
        n = 0;
        while (!rsp_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h8000_0010;
        req_wdata[1] = 32'h0; req_wmask[1] = 4'hF;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", {31'b0, rsp_valid[1]}, 32'd1);
            chk("bp_rdata",     rsp_rdata[1], 32'hDEAD_BEEF);
            chk("bp_err",       {31'b0, rsp_err[1]}, 32'd0);
            chk("bp_req_ready", {31'b0, req_ready[1]}, 32'd0);
            @(negedge clk);
        end
        req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        repeat (3) begin
            chk("bp_no_extra_rsp", {31'b0, rsp_valid[1]}, 32'd0);
            @(negedge clk);
        end
        txn("bp_reload", 1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 0);

        // Out of range: bounds on both sides, and stores must not alias into the array.
        txn("st_word0",  1, 1'b1, BASE,              32'hA0A0_A0A0, 4'hF, 1'b0, 0);
        txn("st_wlast",  1, 1'b1, 32'h8000_0FFC,     32'h5A5A_5A5A, 4'hF, 1'b0, 0);
        txn("ld_wlast",  1, 1'b0, 32'h8000_0FFC,     32'h0, 4'h0, 1'b0, 0);
        txn("oor_ld_lo", 1, 1'b0, 32'h7FFF_FFFC,     32'h0, 4'h0, 1'b0, 0);
        txn("oor_ld_hi", 1, 1'b0, LIMIT,             32'h0, 4'h0, 1'b0, 0);
        txn("oor_st_hi", 1, 1'b1, LIMIT,             32'h1234_5678, 4'hF, 1'b0, 0);
        txn("oor_st_lo", 1, 1'b1, 32'h7FFF_FFFC,     32'h8765_4321, 4'hF, 1'b0, 0);
        txn("oor_chk0",  1, 1'b0, BASE,              32'h0, 4'h0, 1'b0, 0);
        txn("oor_chkN",  1, 1'b0, 32'h8000_0FFC,     32'h0, 4'h0, 1'b0, 0);

        // Reset while a store sits in WAIT: the store must be dropped.
        txn("st_old_0x20", 1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 1'b0, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h8000_0020;
        req_wdata[1] = 32'h1234_5678; req_wmask[1] = 4'hF;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("rstw_rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        chk("rstw_req_ready", {31'b0, req_ready[1]}, 32'd1);
        rst[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstw_idle_valid", {31'b0, rsp_valid[1]}, 32'd0);
        end
        txn("rstw_ld_old", 1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 0);

        // Random-latency instance: seed a 16-word window, then mixed traffic.
        for (int i = 0; i < 16; i++)
            txn("rnd_init", 0, 1'b1, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, 1'b0, 0);
        oor[0] = 32'h7FFF_FFFC; oor[1] = LIMIT; oor[2] = 32'hFFFF_FFFC; oor[3] = 32'h0000_0100;
        for (int i = 0; i < 200; i++) begin
            we = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) a = oor[$urandom_range(0, 3)];
            else a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            txn("rnd", 0, we, a, d, m, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        chk("lfsr_never_zero", {31'b0, lfsr_zero_seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
